// File: rtl/serv_rf_ram_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : serv_rf_ram_sweep
//  Description : RAM-side responder for the SERV register-file SRAM
//                interface. This is a synchronous RAM with one write port
//                and one read port, and a one-cycle read latency. After
//                every reset it runs a clear sweep that writes zero to each
//                stored word, including x0 and the CSR words. The register
//                file then reads as zero without depending on FPGA
//                initial-value support.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     RAM data width. It must be a power of two from 2 to 32 and
//              must match the width used by the bit-serial adapter.
//    CSR_REGS  Number of CSR words stored after the 32 GPRs.
//    RAW/AW/DEPTH are derived from the above and cannot be overridden.
//
//  Ports
//    i_clk        clock
//    i_rst        synchronous reset, active-high
//    i_waddr      write word address             [AW]
//    i_wdata      write data                     [WIDTH]
//    i_wen        write strobe, one word per cycle
//    i_perr_inj   flips the stored parity bit of this write
//                 (only used when parity is enabled)
//    i_raddr      read word address              [AW]
//    i_ren        read strobe
//    o_rdata      read data. It is valid the cycle after i_ren and is held
//                 until the next accepted read.
//    o_init_busy  high while the clear sweep runs; host requests are
//                 ignored during that time
//    o_perr       parity error on the word returned this cycle
//                 (constant 0 when parity is disabled)
//
//  Build option
//    SERV_RF_RAM_PARITY_EN  When defined, each word gets one extra even-parity
//                           bit, and o_perr reports parity mismatches on
//                           reads. When undefined, there is no parity
//                           storage and o_perr is tied low.
// ============================================================================
module serv_rf_ram_sweep #(
    parameter  int WIDTH    = 8,
    parameter  int CSR_REGS = 4,
    localparam int RAW      = $clog2(32 + CSR_REGS),
    localparam int AW       = 5 + RAW - $clog2(WIDTH),
    localparam int DEPTH    = 1 << AW
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_wen,
    input  logic             i_perr_inj,
    input  logic [AW-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_init_busy,
    output logic             o_perr
);

`ifdef SERV_RF_RAM_PARITY_EN
    // The parity bit sits above the data bits of each stored word.
    localparam int c_MW = WIDTH + 1;
`else
    localparam int c_MW = WIDTH;
`endif

    // The last word address, at the sweep counter's width.
    localparam logic [AW:0] c_LAST = (AW + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t           r_state;
    logic [AW:0]      r_scnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_rdata;
    logic [c_MW-1:0]  r_mem [0:DEPTH-1];

    // --------------------------------------------------------------------
    // Write/read port steering.
    // The sweep owns the write port for the whole CLEAR state. Host
    // strobes count only in RUN. An asserted i_rst blocks every access in
    // both states.
    // --------------------------------------------------------------------
    logic             w_clr_wr;
    logic             w_run;
    logic             w_we;
    logic             w_rd;
    logic [AW-1:0]    w_waddr;
    logic [c_MW-1:0]  w_wword;
    logic [c_MW-1:0]  w_rword;

    assign w_clr_wr = (r_state == S_CLEAR) && !i_rst;
    assign w_run    = (r_state == S_RUN)   && !i_rst;
    assign w_we     = w_clr_wr || (w_run && i_wen);
    assign w_rd     = w_run && i_ren;
    assign w_waddr  = w_clr_wr ? r_scnt[AW-1:0] : i_waddr;
    assign w_rword  = r_mem[i_raddr];

`ifdef SERV_RF_RAM_PARITY_EN
    // The sweep stores all zeros, which is valid even parity.
    // Host writes store the even parity of the data, optionally inverted.
    assign w_wword = w_clr_wr ? '0 : {(^i_wdata) ^ i_perr_inj, i_wdata};
`else
    logic w_unused_perr_inj;
    assign w_unused_perr_inj = i_perr_inj;
    assign w_wword = w_clr_wr ? '0 : i_wdata;
`endif

    // --------------------------------------------------------------------
    // Storage.
    // There is no reset on the array; the sweep clears it instead.
    // Reads are sampled in the same edge as writes, so a read and a write
    // to the same address return the old word (read-first).
    // --------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wword;
        end
    end

    // --------------------------------------------------------------------
    // Sequencer and read data register.
    // --------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_CLEAR;
            r_scnt  <= '0;
            r_busy  <= 1'b1;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_scnt <= r_scnt + (AW + 1)'(1);
                    // The final word is written on this same edge, so busy
                    // drops exactly DEPTH cycles after reset is released.
                    if (r_scnt == c_LAST) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_rd) begin
                        r_rdata <= w_rword[WIDTH-1:0];
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_scnt  <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

`ifdef SERV_RF_RAM_PARITY_EN
    // The error flag is a one-cycle pulse that lines up with the data it
    // qualifies. It is low for every cycle that does not return a word.
    logic r_perr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_rd && (w_rword[WIDTH] ^ (^w_rword[WIDTH-1:0]));
        end
    end

    assign o_perr = r_perr;
`else
    assign o_perr = 1'b0;
`endif

    assign o_rdata     = r_rdata;
    assign o_init_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serv_rf_ram_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serv_rf_ram_sweep
//  Description : Scoreboard bench for serv_rf_ram_sweep
//                (default WIDTH=8, CSR_REGS=4, 256 words).
//                Every clock the stimulus side steps a behavioural model and
//                pushes the expected {rdata, perr, busy}. A monitor then pops
//                each expectation on the falling edge and compares it with
//                the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serv_rf_ram_sweep;

    localparam int W     = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic          wen;
    logic          perr_inj;
    logic [AW-1:0] raddr;
    logic          ren;
    logic [W-1:0]  rdata;
    logic          init_busy;
    logic          perr;

    always #5 clk = ~clk;

    serv_rf_ram_sweep #(
        .WIDTH    (W),
        .CSR_REGS (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .i_wen       (wen),
        .i_perr_inj  (perr_inj),
        .i_raddr     (raddr),
        .i_ren       (ren),
        .o_rdata     (rdata),
        .o_init_busy (init_busy),
        .o_perr      (perr)
    );

    typedef struct packed {
        logic [W-1:0] rdata;
        logic         perr;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // ------------------------------------------------------------------
    // Reference model.
    // Reset empties the memory. After release, the next DEPTH edges
    // ignore the host. After that, reads see the pre-write contents.
    // ------------------------------------------------------------------
    logic [W-1:0] m_mem [DEPTH];
`ifdef SERV_RF_RAM_PARITY_EN
    bit           m_bad [DEPTH];
`endif
    int           m_sweep_left = 0;
    logic [W-1:0] m_rdata      = '0;
    logic         m_perr       = 1'b0;

    task automatic step(input bit r, input bit we, input int wa, input int wd,
                        input bit inj, input bit re, input int ra);
        rst      = r;
        wen      = we;
        waddr    = wa[AW-1:0];
        wdata    = wd[W-1:0];
        perr_inj = inj;
        ren      = re;
        raddr    = ra[AW-1:0];
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
`ifdef SERV_RF_RAM_PARITY_EN
                m_bad[i] = 1'b0;
`endif
            end
            m_sweep_left = DEPTH;
            m_rdata      = '0;
            m_perr       = 1'b0;
        end else if (m_sweep_left > 0) begin
            m_sweep_left--;
            m_perr = 1'b0;
        end else begin
            m_perr = 1'b0;
            if (re) begin
                m_rdata = m_mem[ra[AW-1:0]];
`ifdef SERV_RF_RAM_PARITY_EN
                m_perr  = m_bad[ra[AW-1:0]];
`endif
            end
            if (we) begin
                m_mem[wa[AW-1:0]] = wd[W-1:0];
`ifdef SERV_RF_RAM_PARITY_EN
                m_bad[wa[AW-1:0]] = inj;
`endif
            end
        end
        exp_q.push_back('{m_rdata, m_perr, (m_sweep_left > 0)});
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Random host traffic while busy. The DUT must ignore all of it.
    task automatic sweep_with_noise(input int n);
        for (int i = 0; i < n; i++)
            step(0, 1'($urandom), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 255)));
    endtask

    // ------------------------------------------------------------------
    // Monitor.
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                if ({rdata, perr, init_busy} !== mon_e) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t: got rdata=%h perr=%b busy=%b, expected rdata=%h perr=%b busy=%b",
                             $time, rdata, perr, init_busy,
                             mon_e.rdata, mon_e.perr, mon_e.busy);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus.
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        perr_inj = 1'b0; ren = 1'b0; raddr = '0;

        // Single-cycle reset, then a full sweep under noise.
        // A write of A5 to 0x10 is attempted early in the sweep.
        step(1, 0, 0, 0, 0, 0, 0);
        sweep_with_noise(5);
        step(0, 1, 'h10, 'hA5, 1, 1, 'h10);
        sweep_with_noise(DEPTH - 6);
        // Read back every word.
        for (int a = 0; a < DEPTH; a++) step(0, 0, 0, 0, 0, 1, a);
        idle(1);

        // Write 3C to 0x21, read it, then check the value is held for
        // five idle cycles.
        step(0, 1, 'h21, 'h3C, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 'h21);
        idle(5);

        // Same-address read and write: the read returns the old word.
        step(0, 1, 'h05, 'h11, 0, 0, 0);
        step(0, 1, 'h05, 'hFF, 0, 1, 'h05);
        step(0, 0, 0, 0, 0, 1, 'h05);
        // Different addresses in the same cycle.
        step(0, 1, 'h06, 'h5A, 0, 1, 'h21);
        step(0, 0, 0, 0, 0, 1, 'h06);
        idle(2);

        // Reset again mid-sweep, at sweep count 100. The sweep must restart
        // and the old contents must be gone.
        step(0, 1, 'h30, 'h77, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        sweep_with_noise(100);
        step(1, 0, 0, 0, 0, 0, 0);
        sweep_with_noise(DEPTH);
        step(0, 0, 0, 0, 0, 1, 'h30);
        step(0, 0, 0, 0, 0, 1, 'h21);
        step(0, 0, 0, 0, 0, 1, 'h05);
        idle(1);

        // Parity injection. With parity disabled, the model expects no
        // error flag.
        step(0, 1, 'h40, 'h01, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 'h40);
        idle(2);
        step(0, 1, 'h40, 'h01, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 'h40);
        idle(1);

        // Random traffic on a small address window, so that addresses
        // collide often. Resets are rare.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 999) == 0),
                 1'($urandom), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                 1'($urandom), int'($urandom_range(0, 15)));
        end
        idle(2);

        // Let the monitor drain the queue, with a bounded wait.
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
